// File: rtl/matrix_element_sender.sv
// Serialises one signed matrix element as ASCII decimal plus a separator onto a UART TX byte stream.
// Define SENDER_CRLF_EN to emit every newline as CR LF instead of a bare LF.
module matrix_element_sender #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              is_last_col,
  input  logic              newline_only,
  output logic              done,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int KW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND_SIGN,
    SEND_DIG,
    SEND_SEP,
`ifdef SENDER_CRLF_EN
    SEND_CR,
`endif
    SEND_LF,
    DONE
  } state_t;

`ifdef SENDER_CRLF_EN
  localparam state_t     NL_STATE = SEND_CR;
  localparam logic [7:0] NL_BYTE  = 8'h0D;
`else
  localparam state_t     NL_STATE = SEND_LF;
  localparam logic [7:0] NL_BYTE  = 8'h0A;
`endif

  function automatic logic [31:0] pow10_f(input int k);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < k; i++) p = p * 32'd10;
    return p;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  logic [31:0] pow10 [MAX_DIGITS];

  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_pow10
    assign pow10[gi] = pow10_f(gi);
  end

  state_t          state_reg;
  logic [DATA_W:0] mag_reg;
  logic            neg_reg;
  logic            last_col_reg;
  logic [KW-1:0]   k_reg;
  logic [3:0]      cur_digit_reg;
  logic            started_reg;
  logic [KW-1:0]   wr_idx_reg;
  logic [KW-1:0]   last_idx_reg;
  logic [KW-1:0]   send_idx_reg;
  logic [3:0]      digits_reg [MAX_DIGITS];

  logic [KW-1:0]   send_idx_next;
  logic [DATA_W:0] data_mag;

  assign send_idx_next = send_idx_reg + KW'(1);
  // Magnitude is one bit wider so the most negative value has a representable absolute value.
  assign data_mag = data[DATA_W-1] ? (~{1'b1, data} + (DATA_W+1)'(1)) : {1'b0, data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      done          <= 1'b0;
      busy          <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      mag_reg       <= '0;
      neg_reg       <= 1'b0;
      last_col_reg  <= 1'b0;
      k_reg         <= '0;
      cur_digit_reg <= '0;
      started_reg   <= 1'b0;
      wr_idx_reg    <= '0;
      last_idx_reg  <= '0;
      send_idx_reg  <= '0;
      for (int i = 0; i < MAX_DIGITS; i++) digits_reg[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            neg_reg       <= data[DATA_W-1];
            last_col_reg  <= is_last_col;
            mag_reg       <= data_mag;
            k_reg         <= KW'(MAX_DIGITS - 1);
            cur_digit_reg <= '0;
            started_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            send_idx_reg  <= '0;
            if (newline_only) begin
              state_reg <= NL_STATE;
              tx_valid  <= 1'b1;
              tx_data   <= NL_BYTE;
            end else begin
              state_reg <= CONV;
            end
          end
        end

        CONV: begin
          if (32'(mag_reg) >= pow10[k_reg]) begin
            mag_reg       <= mag_reg - pow10[k_reg][DATA_W:0];
            cur_digit_reg <= cur_digit_reg + 4'd1;
          end else begin
            // Digit k is final; keep it unless it is a leading zero (units digit always kept).
            if (cur_digit_reg != 4'd0 || started_reg || k_reg == '0) begin
              digits_reg[wr_idx_reg] <= cur_digit_reg;
              last_idx_reg           <= wr_idx_reg;
              wr_idx_reg             <= wr_idx_reg + KW'(1);
              started_reg            <= 1'b1;
            end
            cur_digit_reg <= '0;
            if (k_reg == '0) begin
              tx_valid <= 1'b1;
              if (neg_reg) begin
                state_reg <= SEND_SIGN;
                tx_data   <= 8'h2D;
              end else begin
                state_reg <= SEND_DIG;
                tx_data   <= ascii_digit(started_reg ? digits_reg[0] : cur_digit_reg);
              end
            end else begin
              k_reg <= k_reg - KW'(1);
            end
          end
        end

        SEND_SIGN: begin
          if (tx_ready) begin
            state_reg    <= SEND_DIG;
            tx_data      <= ascii_digit(digits_reg[0]);
            send_idx_reg <= '0;
          end
        end

        SEND_DIG: begin
          if (tx_ready) begin
            if (send_idx_reg != last_idx_reg) begin
              send_idx_reg <= send_idx_next;
              tx_data      <= ascii_digit(digits_reg[send_idx_next]);
            end else if (last_col_reg) begin
              // Last column skips the space slot and goes straight to the newline.
              state_reg <= NL_STATE;
              tx_data   <= NL_BYTE;
            end else begin
              state_reg <= SEND_SEP;
              tx_data   <= 8'h20;
            end
          end
        end

        SEND_SEP: begin
          if (tx_ready) begin
            state_reg <= DONE;
            tx_valid  <= 1'b0;
            done      <= 1'b1;
          end
        end

`ifdef SENDER_CRLF_EN
        SEND_CR: begin
          if (tx_ready) begin
            state_reg <= SEND_LF;
            tx_data   <= 8'h0A;
          end
        end
`endif

        SEND_LF: begin
          if (tx_ready) begin
            state_reg <= DONE;
            tx_valid  <= 1'b0;
            done      <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          tx_valid  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_element_sender.sv
// Scoreboard bench for matrix_element_sender: expected ASCII bytes are queued at start and
// popped on every TX handshake; also checks done/busy, stall stability and reset abort.
module tb_matrix_element_sender;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] data;
  logic              is_last_col;
  logic              newline_only;
  logic              done;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];

  logic       pend_v = 1'b0;
  logic [7:0] pend_d = 8'h00;

  matrix_element_sender #(.DATA_W(DATA_W), .MAX_DIGITS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .data         (data),
    .is_last_col  (is_last_col),
    .newline_only (newline_only),
    .done         (done),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference formatter built from integer division, independent of the DUT's subtraction scheme.
  task automatic push_expected(input int v, input bit last, input bit nl);
    int m;
    int div;
    if (!nl) begin
      m = (v < 0) ? -v : v;
      if (v < 0) exp_q.push_back(8'h2D);
      div = 1;
      while (div * 10 <= m) div = div * 10;
      while (div > 0) begin
        exp_q.push_back(8'(8'h30 + m / div));
        m = m % div;
        div = div / 10;
      end
      if (!last) exp_q.push_back(8'h20);
    end
    if (nl || last) begin
`ifdef SENDER_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
    end
  endtask

  // Monitor samples mid-cycle, so a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_v) begin
        check_eq("stall_valid_stable", {31'd0, tx_valid}, 32'd1);
        check_eq("stall_data_stable", {24'd0, tx_data}, {24'd0, pend_d});
      end
      if (tx_valid && tx_ready) begin
        check_eq("byte_was_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check_eq("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_at_done", {31'd0, busy}, 32'd1);
        check_eq("valid_low_at_done", {31'd0, tx_valid}, 32'd0);
        check_eq("queue_empty_at_done", exp_q.size(), 32'd0);
      end
    end
    pend_v = rst_n && tx_valid && !tx_ready;
    pend_d = tx_data;
  end

  task automatic run_elem(input int v, input bit last, input bit nl, input int stall, input bit poke);
    int d0;
    int cyc;
    int sc;
    $display("[TB] txn data=%0d last=%0d nl_only=%0d stall=%0d poke=%0d", v, last, nl, stall, poke);
    push_expected(v, last, nl);
    data         = v[DATA_W-1:0];
    is_last_col  = last;
    newline_only = nl;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    d0  = done_cnt;
    cyc = 0;
    sc  = 0;
    while (done_cnt == d0 && cyc < 400) begin
      if (stall > 0) begin
        if (tx_valid && sc < stall) begin
          tx_ready = 1'b0;
          sc++;
        end else begin
          tx_ready = 1'b1;
          sc = 0;
        end
      end else begin
        tx_ready = 1'b1;
      end
      if (poke && cyc == 12) begin
        start = 1'b1;
        data  = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    check_eq("done_count", done_cnt - d0, 32'd1);
    check_eq("done_single_cycle", {31'd0, done}, 32'd0);
    check_eq("busy_low_after", {31'd0, busy}, 32'd0);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_reset_abort();
    int cyc;
    int d0;
    $display("[TB] txn data=42 reset while second digit pending");
    push_expected(42, 1'b0, 1'b0);
    tx_ready     = 1'b1;
    data         = 8'd42;
    is_last_col  = 1'b0;
    newline_only = 1'b0;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b0;
    check_eq("first_digit_sent", exp_q.size(), 32'd2);
    @(posedge clk); #1;
    check_eq("second_digit_pending_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("second_digit_pending_data", {24'd0, tx_data}, 32'h32);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_valid_low", {31'd0, tx_valid}, 32'd0);
    check_eq("abort_busy_low", {31'd0, busy}, 32'd0);
    check_eq("abort_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_done_count", done_cnt - d0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    data         = '0;
    is_last_col  = 1'b0;
    newline_only = 1'b0;
    tx_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_elem(42,   1'b0, 1'b0, 0, 1'b0);
    run_elem(-128, 1'b1, 1'b0, 0, 1'b0);
    run_elem(0,    1'b0, 1'b0, 0, 1'b0);
    run_elem(7,    1'b0, 1'b0, 0, 1'b0);
    run_elem(99,   1'b0, 1'b1, 0, 1'b0);
    run_elem(-5,   1'b0, 1'b0, 5, 1'b1);
    run_elem(55,   1'b1, 1'b1, 0, 1'b0);
    run_elem(100,  1'b1, 1'b0, 0, 1'b0);
    run_elem(127,  1'b0, 1'b0, 2, 1'b0);
    run_elem(-1,   1'b1, 1'b0, 0, 1'b0);
    run_elem(-10,  1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_elem(int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)), 1'b0,
               int'($urandom_range(0, 2)), 1'b0);
    end

    run_reset_abort();
    run_elem(42, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_element_sender.md
Name: matrix_element_sender

Overview:
Downstream stage of the result printer. It takes one signed matrix element per start pulse and serialises it as an ASCII decimal string onto the byte stream feeding the UART transmitter. The number is followed by a separator byte: a space, or a newline when the element is the last column. It can also emit a bare newline. The block sits between the printer and the UART TX byte interface.

Parameters:
DATA_W, 8, width of the signed two's-complement element.
MAX_DIGITS, 3, decimal digit slots; must satisfy 10^MAX_DIGITS > 2^(DATA_W-1).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  single-cycle request; sampled only in IDLE
data  in  DATA_W  signed element; latched on accepted start
is_last_col  in  1  latched with start; 1 = end with newline, 0 = end with space
newline_only  in  1  latched with start; 1 = emit only the newline sequence, ignore data/is_last_col
done  out  1  one-cycle pulse when the full sequence has been handed to the UART
busy  out  1  high from the cycle after an accepted start until the cycle done pulses (inclusive)
tx_data  out  8  ASCII byte to UART TX
tx_valid  out  1  byte valid
tx_ready  in  1  UART accepts byte; transfer when tx_valid && tx_ready on a rising edge

Behaviour:
- Reset (rst_n low at an edge): state IDLE; done=0, busy=0, tx_valid=0, tx_data=8'h00; digit buffer cleared. Applies mid-operation: tx_valid drops at that edge, the sequence is abandoned, no done.
- IDLE: on start=1, latch data, is_last_col and newline_only, then go to CONV. If newline_only=1, go directly to SEND_LF (or SEND_CR with the optional feature). A start outside IDLE is ignored, with no queuing.
- CONV: magnitude = |data|, computed at DATA_W+1 bits so that -2^(DATA_W-1) converts correctly (8-bit -128 gives 128).
  - Digits are extracted MSD first by repeated subtraction of 10^k, k = MAX_DIGITS-1 down to 0, at one subtraction per cycle.
  - Worst case is 10*MAX_DIGITS cycles.
  - Leading zeros are suppressed. A value of 0 yields the single digit '0'.
  - Exit to SEND_SIGN if data<0, else SEND_DIG.
- SEND_SIGN: tx_data=8'h2D ('-'), tx_valid=1 until the handshake, then SEND_DIG.
- SEND_DIG: each digit d is sent as 8'h30+d, one handshake per digit. After the last digit, go to SEND_SEP.
- SEND_SEP: if is_last_col=0, send 8'h20 then DONE. If is_last_col=1, go to SEND_LF (or SEND_CR with the optional feature).
- SEND_LF: send 8'h0A, then DONE.
- DONE: done=1 for exactly one cycle, tx_valid=0, busy=1 in this cycle. The next state is IDLE, so a start in the following cycle is accepted.
- Handshake rules:
  - Once tx_valid rises, tx_data and tx_valid stay stable until the transfer edge.
  - tx_valid never depends combinationally on tx_ready.
  - Back-to-back bytes are allowed: after a transfer edge the next byte may be valid in the following cycle.
  - With tx_ready held high, throughput is 1 byte/cycle after CONV.
- Latency: from start, done arrives at CONV cycles + bytes + 2 cycles when tx_ready is constantly 1.
- newline_only=1 together with is_last_col=1 emits the newline sequence exactly once.

Optional Feature:
Macro SENDER_CRLF_EN.
- Defined: every newline is the two bytes 8'h0D, 8'h0A (state SEND_CR precedes SEND_LF).
- Undefined: newline is the single byte 8'h0A, and the SEND_CR state does not exist.
- Space separators are unaffected either way.

Test Plan:
- data=42, is_last_col=0, tx_ready=1 -> bytes 0x34,0x32,0x20; one done pulse; busy low afterwards.
- data=-128, is_last_col=1 -> bytes 0x2D,0x31,0x32,0x38,0x0A (0x0D,0x0A with SENDER_CRLF_EN); done once.
- data=0, is_last_col=0 -> 0x30,0x20. data=7 -> 0x37,0x20 (no leading zeros).
- newline_only=1, data=99 -> only 0x0A (or 0x0D,0x0A); no digit bytes.
- data=-5 with tx_ready low for 5 cycles on each byte -> tx_data/tx_valid stable throughout; sequence 0x2D,0x35,0x20 unchanged; a start pulsed mid-sequence is ignored.
- rst_n low while the second digit is pending -> tx_valid=0 at that edge, no done; a new start after reset sends a clean sequence.
